// File: rtl/axi_port_arbiter.sv
// rtl/axi_port_arbiter.sv - round-robin sequencer sharing one AXI burst controller between NUM_PORTS requesters
// Optional per-port grant counters (perf_cnt_o, perf_clr_i) are built when AXI_ARB_PERF_EN is defined.
module axi_port_arbiter #(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 64,
   parameter int IDX_W     = 9
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_PORTS-1:0]          req_i,
   input  logic [NUM_PORTS-1:0]          rw_i,
   input  logic [NUM_PORTS*ADDR_W-1:0]   addr_i,
   input  logic [NUM_PORTS*DATA_W-1:0]   wdata_i,
   input  logic [NUM_PORTS*8-1:0]        len_i,
   input  logic [NUM_PORTS*IDX_W-1:0]    fifo_idx_i,
   input  logic [NUM_PORTS-1:0]          fifo_wen_i,
   input  logic [NUM_PORTS-1:0]          fifo_done_i,
   output logic [NUM_PORTS-1:0]          done_o,
   output logic [DATA_W-1:0]             rdata_o,
   output logic                          m_req_o,
   output logic                          m_rw_o,
   output logic [ADDR_W-1:0]             m_addr_o,
   output logic [DATA_W-1:0]             m_wdata_o,
   output logic [7:0]                    m_len_o,
   output logic [IDX_W-1:0]              m_fifo_idx_o,
   output logic                          m_fifo_wen_o,
   output logic                          m_fifo_done_o,
   input  logic [DATA_W-1:0]             m_rdata_i,
   input  logic                          m_done_i,
`ifdef AXI_ARB_PERF_EN
   output logic [NUM_PORTS*32-1:0]       perf_cnt_o,
   input  logic                          perf_clr_i,
`endif
   output logic [NUM_PORTS-1:0]          grant_o
);

   localparam int PTR_W = (NUM_PORTS > 2) ? 2 : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_RELEASE} state_t;

   state_t               r_state;
   logic [PTR_W-1:0]     r_ptr;
   logic [PTR_W-1:0]     r_gidx;
   logic [NUM_PORTS-1:0] r_grant;
   logic [NUM_PORTS-1:0] r_done;
   logic [PTR_W-1:0]     w_sel_idx;
   logic [PTR_W-1:0]     w_next_ptr;
   logic                 w_sel_any;
   logic                 w_xfer;

   // Scan downward so the candidate closest to r_ptr overwrites the others and wins.
   always_comb begin
      logic [PTR_W:0] v_cand;
      w_sel_any = 1'b0;
      w_sel_idx = '0;
      v_cand    = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         v_cand = {1'b0, r_ptr} + (PTR_W+1)'(i);
         if (v_cand >= (PTR_W+1)'(NUM_PORTS))
            v_cand = v_cand - (PTR_W+1)'(NUM_PORTS);
         if (req_i[v_cand[PTR_W-1:0]]) begin
            w_sel_any = 1'b1;
            w_sel_idx = v_cand[PTR_W-1:0];
         end
      end
   end

   assign w_next_ptr = (r_gidx == PTR_W'(NUM_PORTS - 1)) ? '0 : r_gidx + 1'b1;
   assign w_xfer     = (r_state == S_XFER);

   assign m_fifo_idx_o  = w_xfer ? fifo_idx_i[int'(r_gidx)*IDX_W +: IDX_W] : '0;
   assign m_fifo_wen_o  = w_xfer & fifo_wen_i[r_gidx];
   assign m_fifo_done_o = w_xfer & fifo_done_i[r_gidx];
   assign rdata_o       = m_rdata_i;
   assign grant_o       = r_grant;
   assign done_o        = r_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_ptr     <= '0;
         r_gidx    <= '0;
         r_grant   <= '0;
         r_done    <= '0;
         m_req_o   <= 1'b0;
         m_rw_o    <= 1'b0;
         m_addr_o  <= '0;
         m_wdata_o <= '0;
         m_len_o   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_sel_any) begin
                  r_gidx    <= w_sel_idx;
                  r_grant   <= NUM_PORTS'(1) << w_sel_idx;
                  m_rw_o    <= rw_i[w_sel_idx];
                  m_addr_o  <= addr_i[int'(w_sel_idx)*ADDR_W +: ADDR_W];
                  m_wdata_o <= wdata_i[int'(w_sel_idx)*DATA_W +: DATA_W];
                  m_len_o   <= len_i[int'(w_sel_idx)*8 +: 8];
                  m_req_o   <= 1'b1;
                  r_state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (m_done_i) begin
                  m_req_o <= 1'b0;
                  r_done  <= r_grant;
                  r_state <= S_XFER;
               end
            end
            S_XFER: begin
               if (fifo_done_i[r_gidx])
                  r_state <= S_RELEASE;
            end
            S_RELEASE: begin
               r_done  <= '0;
               r_grant <= '0;
               r_ptr   <= w_next_ptr;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef AXI_ARB_PERF_EN
   logic [31:0] r_perf [NUM_PORTS];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int p = 0; p < NUM_PORTS; p++) r_perf[p] <= '0;
      end else if (perf_clr_i) begin
         for (int p = 0; p < NUM_PORTS; p++) r_perf[p] <= '0;
      end else if (r_state == S_ISSUE && m_done_i && r_perf[r_gidx] != 32'hFFFF_FFFF) begin
         r_perf[r_gidx] <= r_perf[r_gidx] + 32'd1;
      end
   end

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_perf
      assign perf_cnt_o[p*32 +: 32] = r_perf[p];
   end
`endif

endmodule

// File: tb/tb_axi_port_arbiter.sv
// tb/tb_axi_port_arbiter.sv - randomized self-checking bench for axi_port_arbiter against a round-robin reference model
module tb_axi_port_arbiter;
   localparam int NP  = 2;
   localparam int AW  = 64;
   localparam int DW  = 64;
   localparam int IW  = 9;
   localparam int FIW = NP * IW;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [NP-1:0]    req_i = '0;
   logic [NP-1:0]    rw_i = '0;
   logic [NP*AW-1:0] addr_i = '0;
   logic [NP*DW-1:0] wdata_i = '0;
   logic [NP*8-1:0]  len_i = '0;
   logic [FIW-1:0]   fifo_idx_i = '0;
   logic [NP-1:0]    fifo_wen_i = '0;
   logic [NP-1:0]    fifo_done_i = '0;
   logic [NP-1:0]    done_o;
   logic [DW-1:0]    rdata_o;
   logic             m_req_o;
   logic             m_rw_o;
   logic [AW-1:0]    m_addr_o;
   logic [DW-1:0]    m_wdata_o;
   logic [7:0]       m_len_o;
   logic [IW-1:0]    m_fifo_idx_o;
   logic             m_fifo_wen_o;
   logic             m_fifo_done_o;
   logic [DW-1:0]    m_rdata_i = '0;
   logic             m_done_i = 1'b0;
   logic [NP-1:0]    grant_o;
`ifdef AXI_ARB_PERF_EN
   logic [NP*32-1:0] perf_cnt_o;
   logic             perf_clr_i = 1'b0;
`endif

   always #5 clk = ~clk;

   axi_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .IDX_W(IW)) dut (
      .clk(clk), .rst(rst),
      .req_i(req_i), .rw_i(rw_i), .addr_i(addr_i), .wdata_i(wdata_i), .len_i(len_i),
      .fifo_idx_i(fifo_idx_i), .fifo_wen_i(fifo_wen_i), .fifo_done_i(fifo_done_i),
      .done_o(done_o), .rdata_o(rdata_o),
      .m_req_o(m_req_o), .m_rw_o(m_rw_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o), .m_len_o(m_len_o),
      .m_fifo_idx_o(m_fifo_idx_o), .m_fifo_wen_o(m_fifo_wen_o), .m_fifo_done_o(m_fifo_done_o),
      .m_rdata_i(m_rdata_i), .m_done_i(m_done_i),
`ifdef AXI_ARB_PERF_EN
      .perf_cnt_o(perf_cnt_o), .perf_clr_i(perf_clr_i),
`endif
      .grant_o(grant_o)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: next-start pointer and completed grants per port.
   int m_ptr = 0;
   int m_cnt [NP];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int exp_winner(input logic [NP-1:0] reqs);
      for (int i = 0; i < NP; i++)
         if (reqs[(m_ptr + i) % NP]) return (m_ptr + i) % NP;
      return -1;
   endfunction

   // Called at a negedge with the DUT idle; leaves the DUT idle at a negedge.
   task automatic run_txn(input logic [NP-1:0] reqs, input int dly, input bit rnd);
      int w;
      int cyc;
      if (rnd) begin
         for (int p = 0; p < NP; p++) begin
            if (reqs[p]) begin
               rw_i[p]            = 1'($urandom_range(0, 1));
               addr_i[p*AW +: AW] = {$urandom, $urandom};
               wdata_i[p*DW +: DW] = {$urandom, $urandom};
               len_i[p*8 +: 8]    = 8'($urandom);
            end
         end
      end
      w = exp_winner(reqs);
      req_i = reqs;
      m_rdata_i = {$urandom, $urandom};
      #1 check("rdata_pass", rdata_o, m_rdata_i);
      cyc = 0;
      @(negedge clk);
      while (!m_req_o && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("req_latency", cyc, 0);
      check("grant", grant_o, NP'(1) << w);
      check("m_rw", m_rw_o, rw_i[w]);
      check("m_addr", m_addr_o, addr_i[w*AW +: AW]);
      check("m_wdata", m_wdata_o, wdata_i[w*DW +: DW]);
      check("m_len", m_len_o, len_i[w*8 +: 8]);
      check("done_in_issue", done_o, 0);
      req_i[w] = 1'b0;
      repeat (dly) begin
         @(negedge clk);
         check("req_hold", m_req_o, 1);
         check("addr_hold", m_addr_o, addr_i[w*AW +: AW]);
         check("wdata_hold", m_wdata_o, wdata_i[w*DW +: DW]);
         check("wen_idle_mask", m_fifo_wen_o, 0);
      end
      m_done_i = 1'b1;
      @(negedge clk);
      check("done_xfer", done_o, NP'(1) << w);
      check("req_drop", m_req_o, 0);
      for (int k = 0; k < 3; k++) begin
         fifo_idx_i  = FIW'($urandom);
         fifo_wen_i  = NP'($urandom);
         fifo_done_i = NP'($urandom) & ~(NP'(1) << w);
         #1;
         check("fifo_idx", m_fifo_idx_o, fifo_idx_i[w*IW +: IW]);
         check("fifo_wen", m_fifo_wen_o, fifo_wen_i[w]);
         check("fifo_done_mask", m_fifo_done_o, 0);
         @(negedge clk);
         check("xfer_hold", done_o, NP'(1) << w);
      end
      fifo_done_i = NP'(1) << w;
      #1 check("fifo_done", m_fifo_done_o, 1);
      @(negedge clk);
      fifo_done_i = '0;
      m_done_i    = 1'b0;
      fifo_wen_i  = '1;
      #1;
      check("release_done", done_o, NP'(1) << w);
      check("release_wen_mask", m_fifo_wen_o, 0);
      @(negedge clk);
      fifo_wen_i = '0;
      check("idle_grant", grant_o, 0);
      check("idle_done", done_o, 0);
      m_ptr = (w + 1) % NP;
      m_cnt[w]++;
   endtask

   initial begin
      for (int p = 0; p < NP; p++) m_cnt[p] = 0;
      @(negedge clk);
      check("rst_grant", grant_o, 0);
      check("rst_done", done_o, 0);
      check("rst_req", m_req_o, 0);
      check("rst_addr", m_addr_o, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      rw_i[0] = 1'b0; addr_i[0 +: AW] = 64'h8000_0000; len_i[0 +: 8] = 8'd7;
      run_txn(2'b01, 2, 1'b0);
      check("single_ptr", m_ptr, 1);

      for (int t = 0; t < 4; t++) run_txn(2'b11, 1, 1'b1);

      rw_i[1] = 1'b1; wdata_i[DW +: DW] = 64'hDEAD_BEEF_0123_4567; addr_i[AW +: AW] = 64'h40;
      run_txn(2'b10, 3, 1'b0);

      run_txn(2'b01, 0, 1'b1);
      run_txn(2'b01, 1, 1'b1);

      for (int t = 0; t < 40; t++) run_txn(NP'($urandom_range(1, 3)), $urandom_range(0, 3), 1'b1);

      addr_i[0 +: AW] = 64'h1234; rw_i[0] = 1'b1; len_i[0 +: 8] = 8'd3;
      req_i = 2'b01;
      @(negedge clk);
      m_done_i = 1'b1;
      @(negedge clk);
      fifo_wen_i = 2'b01;
      #1 check("pre_rst_wen", m_fifo_wen_o, 1);
      #2 rst = 1'b0;
      #1;
      check("arst_grant", grant_o, 0);
      check("arst_done", done_o, 0);
      check("arst_req", m_req_o, 0);
      check("arst_rw", m_rw_o, 0);
      check("arst_addr", m_addr_o, 0);
      check("arst_wdata", m_wdata_o, 0);
      check("arst_len", m_len_o, 0);
      check("arst_wen", m_fifo_wen_o, 0);
      req_i = '0; m_done_i = 1'b0; fifo_wen_i = '0;
      @(negedge clk);
      rst = 1'b1;
      m_ptr = 0;
      for (int p = 0; p < NP; p++) m_cnt[p] = 0;
      @(negedge clk);
      run_txn(2'b10, 1, 1'b1);
      for (int t = 0; t < 4; t++) run_txn(NP'($urandom_range(1, 3)), 1, 1'b1);

`ifdef AXI_ARB_PERF_EN
      for (int p = 0; p < NP; p++) check("perf_cnt", perf_cnt_o[p*32 +: 32], m_cnt[p]);
      perf_clr_i = 1'b1;
      @(negedge clk);
      perf_clr_i = 1'b0;
      for (int p = 0; p < NP; p++) check("perf_clr", perf_cnt_o[p*32 +: 32], 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/axi_port_arbiter.md
Name: axi_port_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single AXI burst controller between NUM_PORTS cache-side requesters (I-cache, D-cache, later uncached/DMA).
- Sits between the cache miss/writeback FSMs and the AXI controller's user port.
- Owns the controller end-to-end, from request through fifo exchange, so one port is serviced at a time.
- Replaces fixed port priority with fair, starvation-free selection.

Parameters:
- NUM_PORTS, 2, number of requesters (2..4).
- ADDR_W, 64, request address width.
- DATA_W, 64, request/fifo data width.
- IDX_W, 9, cache fifo bit-index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req_i  in  NUM_PORTS  per-port transfer request (level).
- rw_i  in  NUM_PORTS  per-port direction, 0=read, 1=write.
- addr_i  in  NUM_PORTS*ADDR_W  per-port address, port p at [p*ADDR_W+:ADDR_W].
- wdata_i  in  NUM_PORTS*DATA_W  per-port write data.
- len_i  in  NUM_PORTS*8  per-port burst length.
- fifo_idx_i  in  NUM_PORTS*IDX_W  per-port fifo bit index.
- fifo_wen_i  in  NUM_PORTS  per-port fifo write strobe.
- fifo_done_i  in  NUM_PORTS  per-port fifo-exchange-complete pulse.
- done_o  out  NUM_PORTS  per-port grant-complete; one-hot or zero.
- rdata_o  out  DATA_W  fifo read data, broadcast to all ports.
- m_req_o  out  1  request to controller.
- m_rw_o  out  1  direction to controller.
- m_addr_o  out  ADDR_W  address to controller.
- m_wdata_o  out  DATA_W  write data to controller.
- m_len_o  out  8  burst length to controller.
- m_fifo_idx_o  out  IDX_W  muxed fifo index.
- m_fifo_wen_o  out  1  muxed fifo write strobe.
- m_fifo_done_o  out  1  muxed fifo done.
- m_rdata_i  in  DATA_W  controller fifo data.
- m_done_i  in  1  controller done; level, held until fifo_done.
- grant_o  out  NUM_PORTS  one-hot current owner; 0 when idle.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state IDLE, ptr=0, grant_o=0, done_o=0.
  - m_req_o=0, m_rw_o=0, m_addr_o=0, m_wdata_o=0, m_len_o=0.
  - Reset mid-transfer aborts immediately; no done_o is issued for the aborted request.
- FSM states: IDLE, ISSUE, XFER, RELEASE.
- IDLE:
  - If any req_i is set, select the first requesting port scanning from ptr upward, modulo NUM_PORTS.
  - Latch that port's rw/addr/wdata/len into the m_* registers, set grant_o one-hot, go to ISSUE.
  - Selection takes one cycle; m_req_o rises the cycle after req_i is sampled.
- ISSUE:
  - m_req_o=1 and m_* attributes are held stable.
  - When m_done_i=1: m_req_o<=0, done_o[g]<=1, go to XFER.
  - A requester deasserting req_i in ISSUE is ignored (protocol violation). The latched request still completes.
- XFER:
  - Combinationally forward fifo_idx_i, fifo_wen_i and fifo_done_i of the granted port only; non-granted strobes are masked to 0.
  - done_o[g] stays 1.
  - On fifo_done_i[g]=1, go to RELEASE.
- RELEASE (one cycle):
  - done_o<=0, grant_o<=0, ptr<=(g+1) mod NUM_PORTS, go to IDLE.
  - Requests present during RELEASE are not sampled; earliest re-grant is the following IDLE cycle.
- Outside XFER: m_fifo_wen_o=0, m_fifo_done_o=0, m_fifo_idx_o=0.
- rdata_o = m_rdata_i, unconditionally.
- Simultaneous requests: the port at or after ptr wins. With both ports continuously requesting, grants strictly alternate.
- A back-to-back request from the same port is accepted only if no other port is requesting.
- ptr arithmetic wraps at NUM_PORTS, not 2^k.

Optional Feature:
- Macro AXI_ARB_PERF_EN.
- When defined, adds output perf_cnt_o (NUM_PORTS*32):
  - One counter per port, incremented on each ISSUE->XFER transition for that port.
  - Saturates at 0xFFFF_FFFF; cleared by reset.
  - Adds input perf_clr_i (1): synchronous clear of all counters, with priority over increment.
- When not defined, neither port nor counters exist, and behaviour is otherwise identical.

Test Plan:
- Single read: port0 req, rw=0, addr=0x8000_0000, len=7; m_done_i two cycles after m_req_o; fifo_done pulse 10 cycles later -> m_req_o high from cycle 1, m_addr_o=0x8000_0000, m_len_o=7; done_o=01 until the cycle after fifo_done; grant_o returns to 0; ptr=1.
- Simultaneous requests: req_i=11 held for 4 transactions -> grant order 0,1,0,1; done_o never has two bits set.
- Fifo masking: port1 granted, port0 toggles fifo_wen_i/fifo_done_i -> m_fifo_wen_o and m_fifo_done_o follow port1 only; port0's fifo_done does not end the transfer.
- Write pass-through: port1 rw=1, wdata=0xDEAD_BEEF_0123_4567 -> m_rw_o=1, m_wdata_o equal and stable throughout ISSUE; rdata_o tracks m_rdata_i.
- Reset mid-XFER: assert rst=0 asynchronously -> all outputs 0 within the same cycle; after release, port1 requesting alone is granted normally.
- AXI_ARB_PERF_EN: 3 grants to port0, 2 to port1 -> perf_cnt_o = {2,3}; perf_clr_i pulse -> {0,0}.
